// File: rtl/aurora_mon_pkg.sv
// Shared types and defaults for the Aurora runtime link monitor.
package aurora_mon_pkg;

    typedef enum logic [2:0] {
        WAIT_INIT = 3'd0,
        WAIT_UP   = 3'd1,
        UP        = 3'd2,
        RETRY_CHK = 3'd3,
        REINIT    = 3'd4,
        FAILED    = 3'd5
    } mon_state_e;

    localparam int UP_TIMEOUT_DEF      = 20000;
    localparam int DOWN_FILTER_DEF     = 8;
    localparam int REINIT_LEN_DEF      = 63;
    localparam int MAX_RETRIES_DEF     = 4;
    localparam int SOFT_ERR_THRESH_DEF = 16;
    localparam int SYNC_STAGES_DEF     = 2;

    localparam int RETRY_CNT_W = 3;
    localparam int SOFT_CNT_W  = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/aurora_sync_bit.sv
// Single-bit multi-flop synchroniser into the init_clk domain.
module aurora_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic init_clk,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge init_clk) begin
        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/aurora_link_monitor.sv
// Runtime Aurora link watchdog: retries GT/core reset on link loss, flags permanent failure.
// Optional soft-error retry counting is enabled by defining AURORA_MON_SOFTERR_EN.
module aurora_link_monitor
    import aurora_mon_pkg::*;
#(
    parameter int UP_TIMEOUT      = UP_TIMEOUT_DEF,
    parameter int DOWN_FILTER     = DOWN_FILTER_DEF,
    parameter int REINIT_LEN      = REINIT_LEN_DEF,
    parameter int MAX_RETRIES     = MAX_RETRIES_DEF,
    parameter int SOFT_ERR_THRESH = SOFT_ERR_THRESH_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic                   init_clk,
    input  logic                   RST,
    input  logic                   init_done,
    input  logic                   channel_up,
    input  logic                   lane_up,
    input  logic                   hard_err,
    input  logic                   soft_err,
    output logic                   reinit_gt_reset,
    output logic                   reinit_reset,
    output logic                   link_ok,
    output logic                   link_failed,
    output logic [RETRY_CNT_W-1:0] retry_cnt,
    output logic [SOFT_CNT_W-1:0]  soft_err_cnt
);

    localparam int TMR_W  = $clog2(max_int(UP_TIMEOUT, REINIT_LEN) + 1);
    localparam int DCNT_W = $clog2(DOWN_FILTER + 1);

    mon_state_e        state, next_state;
    logic [TMR_W-1:0]  timer;
    logic [DCNT_W-1:0] down_cnt;
    logic [3:0]        async_in, sync_q;
    logic              channel_up_s, lane_up_s, hard_err_s, soft_err_s;
    logic              soft_trip;
    logic              link_ok_d, link_failed_d, reinit_d;

    assign async_in = {soft_err, hard_err, lane_up, channel_up};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            aurora_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
                .init_clk (init_clk),
                .d        (async_in[gi]),
                .q        (sync_q[gi])
            );
        end
    endgenerate

    assign {soft_err_s, hard_err_s, lane_up_s, channel_up_s} = sync_q;

`ifdef AURORA_MON_SOFTERR_EN
    logic soft_err_q;

    always_ff @(posedge init_clk) begin
        if (RST) soft_err_q <= 1'b0;
        else     soft_err_q <= soft_err_s;
    end

    // Counter restarts on REINIT entry so each UP period is judged on its own.
    always_ff @(posedge init_clk) begin
        if (RST)
            soft_err_cnt <= '0;
        else if (state != REINIT && next_state == REINIT)
            soft_err_cnt <= '0;
        else if (state == UP && soft_err_s && !soft_err_q && soft_err_cnt != '1)
            soft_err_cnt <= soft_err_cnt + SOFT_CNT_W'(1);
    end

    assign soft_trip = (int'(soft_err_cnt) >= SOFT_ERR_THRESH);
`else
    logic unused_soft;
    assign unused_soft  = &{1'b0, soft_err_s, SOFT_ERR_THRESH[0]};
    assign soft_err_cnt = '0;
    assign soft_trip    = 1'b0;
`endif

    always_ff @(posedge init_clk) begin
        if (RST) begin
            state     <= WAIT_INIT;
            timer     <= '0;
            down_cnt  <= '0;
            retry_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state != state)
                timer <= '0;
            else if (state == WAIT_UP || state == REINIT)
                timer <= timer + TMR_W'(1);
            if (state == UP && next_state == UP && !channel_up_s)
                down_cnt <= down_cnt + DCNT_W'(1);
            else
                down_cnt <= '0;
            if (state == RETRY_CHK && next_state == REINIT && retry_cnt != '1)
                retry_cnt <= retry_cnt + RETRY_CNT_W'(1);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            WAIT_INIT: if (init_done) next_state = WAIT_UP;
            // hard_err beats a simultaneous channel_up
            WAIT_UP: begin
                if (hard_err_s)
                    next_state = RETRY_CHK;
                else if (channel_up_s && lane_up_s)
                    next_state = UP;
                else if (timer == TMR_W'(UP_TIMEOUT - 1))
                    next_state = RETRY_CHK;
            end
            UP: begin
                if (hard_err_s ||
                    (!channel_up_s && down_cnt == DCNT_W'(DOWN_FILTER - 1)) ||
                    soft_trip)
                    next_state = RETRY_CHK;
            end
            RETRY_CHK: next_state = (int'(retry_cnt) < MAX_RETRIES) ? REINIT : FAILED;
            REINIT:    if (timer == TMR_W'(REINIT_LEN - 1)) next_state = WAIT_UP;
            FAILED:    next_state = FAILED;
            default:   next_state = WAIT_INIT;
        endcase
    end

    // link flags track the state register; reinit pulse lags REINIT by one cycle
    always_comb begin
        link_ok_d     = (next_state == UP);
        link_failed_d = (next_state == FAILED);
        reinit_d      = (state == REINIT);
    end

    always_ff @(posedge init_clk) begin
        if (RST) begin
            link_ok         <= 1'b0;
            link_failed     <= 1'b0;
            reinit_gt_reset <= 1'b0;
            reinit_reset    <= 1'b0;
        end else begin
            link_ok         <= link_ok_d;
            link_failed     <= link_failed_d;
            reinit_gt_reset <= reinit_d;
            reinit_reset    <= reinit_d;
        end
    end

endmodule
